// File: rtl/clip_transfer_sequencer.sv
// rtl/clip_transfer_sequencer.sv - moves samples between the deserializer, two clip banks and the serializer
module clip_transfer_sequencer #(
   parameter int ADDR_WIDTH   = 16,
   parameter int CLIP_SAMPLES = 50000,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  record_start_i,
   input  logic                  play_start_i,
   input  logic                  stop_i,
   input  logic                  clip_sel_i,
   input  logic                  deserializer_valid_i,
   input  logic [15:0]           deserializer_data_i,
   output logic                  deserializer_enable_o,
   input  logic                  serializer_ready_i,
   output logic                  serializer_load_o,
   output logic [15:0]           serializer_data_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [1:0]            mem_en_o,
   output logic [1:0]            mem_we_o,
   output logic [15:0]           mem_din_o,
   input  logic [15:0]           mem_dout0_i,
   input  logic [15:0]           mem_dout1_i,
   output logic                  recording_o,
   output logic                  playing_o,
   output logic                  active_clip_o,
   output logic                  done_o
);

   typedef enum logic [2:0] {
      IDLE, RECORD, PLAY_READ, PLAY_WAIT, PLAY_LOAD, PLAY_HOLD, DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] CLIP_LEN  = (ADDR_WIDTH+1)'(CLIP_SAMPLES);
   localparam logic [ADDR_WIDTH:0] CLIP_LAST = CLIP_LEN - 1'b1;
   localparam logic [1:0]          WAIT_LAST = 2'(READ_LATENCY - 1);

   state_t              state, state_nx;
   logic [ADDR_WIDTH:0] count, count_nx;
   logic [ADDR_WIDTH:0] len0, len1, len0_nx, len1_nx;
   logic [ADDR_WIDTH:0] cur_len, sel_len, new_len;
   logic                store_len;
   logic                clip, clip_nx;
   logic                wr_pending;
   logic [15:0]         wr_data;
   logic [1:0]          wait_cnt, wait_nx;
   logic [15:0]         ser_data, ser_data_nx;
   logic [1:0]          bank_mask;

   assign cur_len           = clip ? len1 : len0;
   assign sel_len           = clip_sel_i ? len1 : len0;
   assign bank_mask         = clip ? 2'b10 : 2'b01;
   assign serializer_data_o = ser_data;
   assign active_clip_o     = clip;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= IDLE;
         count      <= '0;
         len0       <= '0;
         len1       <= '0;
         clip       <= 1'b0;
         wr_pending <= 1'b0;
         wr_data    <= '0;
         wait_cnt   <= '0;
         ser_data   <= '0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         len0       <= len0_nx;
         len1       <= len1_nx;
         clip       <= clip_nx;
         // A sample is only accepted while the recording continues next cycle.
         wr_pending <= deserializer_valid_i && (state == RECORD) && (state_nx == RECORD);
         wr_data    <= deserializer_data_i;
         wait_cnt   <= wait_nx;
         ser_data   <= ser_data_nx;
      end
   end

   always_comb begin
      state_nx              = state;
      count_nx              = count;
      clip_nx               = clip;
      wait_nx               = wait_cnt;
      ser_data_nx           = ser_data;
      new_len               = '0;
      store_len             = 1'b0;
      deserializer_enable_o = 1'b0;
      serializer_load_o     = 1'b0;
      mem_addr_o            = '0;
      mem_en_o              = 2'b00;
      mem_we_o              = 2'b00;
      mem_din_o             = '0;
      recording_o           = 1'b0;
      playing_o             = 1'b0;
      done_o                = 1'b0;

      case (state)
         IDLE: begin
            if (record_start_i) begin
               clip_nx  = clip_sel_i;
               count_nx = '0;
               state_nx = RECORD;
            end else if (play_start_i) begin
               clip_nx  = clip_sel_i;
               count_nx = '0;
               state_nx = (sel_len == '0) ? DONE : PLAY_READ;
            end
         end
         RECORD: begin
            deserializer_enable_o = 1'b1;
            recording_o           = 1'b1;
            if (wr_pending) begin
               mem_en_o   = bank_mask;
               mem_we_o   = bank_mask;
               mem_addr_o = count[ADDR_WIDTH-1:0];
               mem_din_o  = wr_data;
               count_nx   = count + 1'b1;
            end
            if (stop_i) begin
               new_len   = count + (ADDR_WIDTH+1)'(wr_pending);
               store_len = 1'b1;
               state_nx  = DONE;
            end else if (wr_pending && count == CLIP_LAST) begin
               new_len   = CLIP_LEN;
               store_len = 1'b1;
               state_nx  = DONE;
            end
         end
         PLAY_READ: begin
            playing_o  = 1'b1;
            mem_en_o   = bank_mask;
            mem_addr_o = count[ADDR_WIDTH-1:0];
            wait_nx    = '0;
            state_nx   = stop_i ? DONE : PLAY_WAIT;
         end
         PLAY_WAIT: begin
            playing_o = 1'b1;
            if (stop_i) begin
               state_nx = DONE;
            end else if (wait_cnt == WAIT_LAST) begin
               ser_data_nx = clip ? mem_dout1_i : mem_dout0_i;
               state_nx    = PLAY_LOAD;
            end else begin
               wait_nx = wait_cnt + 2'd1;
            end
         end
         PLAY_LOAD: begin
            playing_o = 1'b1;
            if (stop_i) begin
               state_nx = DONE;
            end else if (serializer_ready_i) begin
               serializer_load_o = 1'b1;
               count_nx          = count + 1'b1;
               state_nx          = PLAY_HOLD;
            end
         end
         PLAY_HOLD: begin
            playing_o = 1'b1;
            if (stop_i || count == cur_len) state_nx = DONE;
            else                            state_nx = PLAY_READ;
         end
         DONE: begin
            done_o   = 1'b1;
            count_nx = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      len0_nx = (store_len && !clip) ? new_len : len0;
      len1_nx = (store_len &&  clip) ? new_len : len1;
   end

endmodule

// File: tb/tb_clip_transfer_sequencer.sv
// tb/tb_clip_transfer_sequencer.sv - self-checking bench for clip_transfer_sequencer
module tb_clip_transfer_sequencer;

   localparam int AW = 4;
   localparam int CS = 8;
   localparam int RL = 2;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          record_start_i = 1'b0, play_start_i = 1'b0, stop_i = 1'b0, clip_sel_i = 1'b0;
   logic          deserializer_valid_i = 1'b0;
   logic [15:0]   deserializer_data_i = '0;
   logic          deserializer_enable_o;
   logic          serializer_ready_i = 1'b0;
   logic          serializer_load_o;
   logic [15:0]   serializer_data_o;
   logic [AW-1:0] mem_addr_o;
   logic [1:0]    mem_en_o, mem_we_o;
   logic [15:0]   mem_din_o, mem_dout0_i, mem_dout1_i;
   logic          recording_o, playing_o, active_clip_o, done_o;

   clip_transfer_sequencer #(.ADDR_WIDTH(AW), .CLIP_SAMPLES(CS), .READ_LATENCY(RL)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .record_start_i(record_start_i), .play_start_i(play_start_i), .stop_i(stop_i),
      .clip_sel_i(clip_sel_i),
      .deserializer_valid_i(deserializer_valid_i), .deserializer_data_i(deserializer_data_i),
      .deserializer_enable_o(deserializer_enable_o),
      .serializer_ready_i(serializer_ready_i), .serializer_load_o(serializer_load_o),
      .serializer_data_o(serializer_data_o),
      .mem_addr_o(mem_addr_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_din_o(mem_din_o),
      .mem_dout0_i(mem_dout0_i), .mem_dout1_i(mem_dout1_i),
      .recording_o(recording_o), .playing_o(playing_o), .active_clip_o(active_clip_o),
      .done_o(done_o)
   );

   always #5 clock_i = ~clock_i;

   // Two block RAMs with RL cycles of read latency.
   logic [15:0] bank0 [16];
   logic [15:0] bank1 [16];
   logic [15:0] pipe0 [RL];
   logic [15:0] pipe1 [RL];
   assign mem_dout0_i = pipe0[RL-1];
   assign mem_dout1_i = pipe1[RL-1];

   always @(posedge clock_i) begin
      if (mem_en_o[0] && mem_we_o[0]) bank0[mem_addr_o] <= mem_din_o;
      if (mem_en_o[1] && mem_we_o[1]) bank1[mem_addr_o] <= mem_din_o;
      if (mem_en_o[0]) pipe0[0] <= bank0[mem_addr_o];
      if (mem_en_o[1]) pipe1[0] <= bank1[mem_addr_o];
      for (int i = 1; i < RL; i++) begin
         pipe0[i] <= pipe0[i-1];
         pipe1[i] <= pipe1[i-1];
      end
   end

   // Observed traffic, collected away from the active edge.
   logic [23:0] wq[$];
   logic [15:0] lq[$];
   int done_cnt, en_cnt, bad_bank;

   always @(negedge clock_i) begin
      if (mem_we_o != 2'b00) wq.push_back({mem_en_o, mem_we_o, mem_addr_o, mem_din_o});
      if (serializer_load_o) lq.push_back(serializer_data_o);
      if (done_o) done_cnt++;
      if (mem_en_o != 2'b00) en_cnt++;
      if (mem_en_o == 2'b11 || (mem_en_o & (active_clip_o ? 2'b01 : 2'b10)) != 2'b00) bad_bank++;
   end

   // Reference model: what each clip should hold, in order.
   logic [15:0] exp_mem [2][$];

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic clear_obs();
      wq.delete();
      lq.delete();
      done_cnt = 0;
      en_cnt   = 0;
   endtask

   task automatic wait_done(input string tag, input bit rand_ready, output int cycles);
      cycles = 0;
      while (done_cnt == 0 && cycles < 300) begin
         if (rand_ready) serializer_ready_i = 1'($urandom);
         tick();
         cycles++;
      end
      serializer_ready_i = 1'b0;
      repeat (3) tick();
      chk({tag, "_done_pulse"}, done_cnt, 1);
   endtask

   task automatic start(input bit rec, input bit play, input bit sel);
      record_start_i = rec;
      play_start_i   = play;
      clip_sel_i     = sel;
      tick();
      record_start_i = 1'b0;
      play_start_i   = 1'b0;
   endtask

   task automatic feed(input bit sel, input int n, input bit gaps);
      logic [15:0] d;
      for (int i = 0; i < n; i++) begin
         d = 16'($urandom);
         if (i < CS) exp_mem[sel].push_back(d);
         deserializer_valid_i = 1'b1;
         deserializer_data_i  = d;
         tick();
         deserializer_valid_i = 1'b0;
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
      tick();
   endtask

   task automatic check_writes(input string tag, input bit sel);
      logic [1:0] m;
      m = sel ? 2'b10 : 2'b01;
      chk({tag, "_wr_count"}, wq.size(), exp_mem[sel].size());
      for (int i = 0; i < wq.size() && i < exp_mem[sel].size(); i++)
         chk($sformatf("%s_wr%0d", tag, i), wq[i], {m, m, AW'(i), exp_mem[sel][i]});
   endtask

   task automatic check_loads(input string tag, input bit sel, input int n);
      chk({tag, "_load_count"}, lq.size(), n);
      for (int i = 0; i < lq.size() && i < n; i++)
         chk($sformatf("%s_load%0d", tag, i), lq[i], exp_mem[sel][i]);
      chk({tag, "_no_writes"}, wq.size(), 0);
   endtask

   function automatic logic [63:0] all_outs();
      return {deserializer_enable_o, serializer_load_o, serializer_data_o, mem_addr_o, mem_en_o,
              mem_we_o, mem_din_o, recording_o, playing_o, active_clip_o, done_o};
   endfunction

   initial begin
      int cyc;
      for (int i = 0; i < 16; i++) begin
         bank0[i] = '0;
         bank1[i] = '0;
      end
      for (int i = 0; i < RL; i++) begin
         pipe0[i] = '0;
         pipe1[i] = '0;
      end
      done_cnt = 0; en_cnt = 0; bad_bank = 0;

      // Reset state
      reset_i = 1'b1;
      repeat (2) tick();
      chk("reset_outputs", all_outs(), 0);
      reset_i = 1'b0;
      tick();

      // Record 5 samples into clip 0 then stop
      clear_obs();
      start(1'b1, 1'b0, 1'b0);
      chk("rec0_recording", {recording_o, playing_o, active_clip_o, deserializer_enable_o}, 4'b1001);
      feed(1'b0, 5, 1'b0);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wait_done("rec0", 1'b0, cyc);
      check_writes("rec0", 1'b0);
      chk("rec0_idle", {recording_o, playing_o}, 2'b00);

      // Play clip 0 with ready tied high
      clear_obs();
      serializer_ready_i = 1'b1;
      start(1'b0, 1'b1, 1'b0);
      chk("play0_playing", playing_o, 1'b1);
      serializer_ready_i = 1'b1;
      cyc = 0;
      while (done_cnt == 0 && cyc < 300) begin tick(); cyc++; end
      serializer_ready_i = 1'b0;
      repeat (3) tick();
      chk("play0_done_pulse", done_cnt, 1);
      check_loads("play0", 1'b0, 5);

      // Record 10 random, gapped samples into clip 1: capacity stops it at CS
      clear_obs();
      start(1'b1, 1'b0, 1'b1);
      feed(1'b1, 10, 1'b1);
      wait_done("rec1", 1'b0, cyc);
      check_writes("rec1", 1'b1);

      // Play clip 1 with a randomly toggling ready
      clear_obs();
      start(1'b0, 1'b1, 1'b1);
      wait_done("play1", 1'b1, cyc);
      check_loads("play1", 1'b1, CS);

      // Simultaneous starts: record wins; play during record ignored
      clear_obs();
      exp_mem[0].delete();
      start(1'b1, 1'b1, 1'b0);
      chk("both_start_record", {recording_o, playing_o}, 2'b10);
      start(1'b0, 1'b1, 1'b0);
      chk("play_in_record_ignored", {recording_o, playing_o}, 2'b10);
      feed(1'b0, 3, 1'b0);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wait_done("rec0b", 1'b0, cyc);
      check_writes("rec0b", 1'b0);

      // Stop mid-play after two loads
      clear_obs();
      serializer_ready_i = 1'b1;
      start(1'b0, 1'b1, 1'b0);
      cyc = 0;
      while (lq.size() < 2 && cyc < 100) begin tick(); cyc++; end
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      wait_done("stop_play", 1'b0, cyc);
      check_loads("stop_play", 1'b0, 2);

      // Asynchronous reset in the middle of a recording
      clear_obs();
      start(1'b1, 1'b0, 1'b1);
      deserializer_valid_i = 1'b1;
      deserializer_data_i  = 16'($urandom);
      tick();
      deserializer_valid_i = 1'b0;
      @(posedge clock_i);
      #2 reset_i = 1'b1;
      #1 chk("async_reset_outputs", all_outs(), 0);
      repeat (2) tick();
      reset_i = 1'b0;
      tick();

      // Lengths were cleared, so both clips play back as empty
      for (int c = 0; c < 2; c++) begin
         clear_obs();
         start(1'b0, 1'b1, 1'(c));
         wait_done($sformatf("empty_play%0d", c), 1'b1, cyc);
         chk($sformatf("empty_play%0d_latency", c), cyc <= 1, 1'b1);
         chk($sformatf("empty_play%0d_no_mem", c), en_cnt, 0);
         chk($sformatf("empty_play%0d_no_load", c), lq.size(), 0);
      end

      chk("bank_exclusive", bad_bank, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
